// File: rtl/dram_audio_fetcher.sv
// Per-tick DRAM fetch engine for drum voice playback.
// On each audio sample tick one word-address request goes out per active voice.
// Tagged read responses are matched back to the voices still waiting on that word.
// All voice samples are then published together as one registered set.
//
// read_addr_axis: a beat transfers on a cycle where valid && ready are both high.
// Once valid rises, data, tlast and valid stay stable until that transfer happens.
// read_data_audio_axis: ready is held high after reset, so every valid cycle is one response.
module dram_audio_fetcher #(
   parameter int VOICES         = 8,
   parameter int ADDR_WIDTH     = 24,
   parameter int SAMPLE_WIDTH   = 16,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                             clk_dram_ctrl,
   input  logic                             rst_dram_ctrl_n,
   input  logic                             sample_tick,
   input  logic [VOICES-1:0]                voice_active,
   input  logic [VOICES*(ADDR_WIDTH+3)-1:0] voice_sample_index,
   output logic [ADDR_WIDTH-1:0]            read_addr_axis_data,
   output logic                             read_addr_axis_valid,
   input  logic                             read_addr_axis_ready,
   output logic                             read_addr_axis_tlast,
   input  logic [ADDR_WIDTH+127:0]          read_data_audio_axis_data,
   input  logic                             read_data_audio_axis_valid,
   output logic                             read_data_audio_axis_ready,
   output logic [VOICES*SAMPLE_WIDTH-1:0]   voice_sample,
   output logic                             samples_valid,
   output logic                             fetch_timeout,
   output logic                             tick_overrun,
   output logic                             stale_drop
);

   localparam int IW = ADDR_WIDTH + 3;
   localparam int VW = (VOICES > 1) ? $clog2(VOICES) : 1;
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t                  state_q, state_d;
   logic [VW-1:0]           v_q, v_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic [VOICES-1:0]       act_q;
   logic [VOICES*IW-1:0]    idx_q;
   logic [VOICES-1:0]       pending_q;
   logic [VOICES-1:0]       got_q;
   logic [SAMPLE_WIDTH-1:0] shadow_q [VOICES];

   logic                    tick_accept;
   logic                    advance;
   logic                    timeout_hit;
   logic                    act_above;
   logic [VOICES-1:0]       issue_set;
   logic [VOICES-1:0]       match;
   logic [ADDR_WIDTH-1:0]   resp_addr;
   logic [127:0]            resp_data;
   logic [SAMPLE_WIDTH-1:0] resp_sample [VOICES];

   assign resp_addr   = read_data_audio_axis_data[ADDR_WIDTH+127:128];
   assign resp_data   = read_data_audio_axis_data[127:0];
   assign tick_accept = sample_tick && (state_q == IDLE);

   // Find out whether any voice above the current one still needs a request (drives tlast).
   always_comb begin
      act_above = 1'b0;
      for (int i = 0; i < VOICES; i++) begin
         if ((i > int'(v_q)) && act_q[i]) act_above = 1'b1;
      end
   end

   // Match a response against voices that were already pending, and pick each voice's lane.
   // pending_q is the registered mask, so a request issued this cycle cannot match yet.
   always_comb begin
      match = '0;
      for (int i = 0; i < VOICES; i++) begin
         resp_sample[i] = resp_data[int'(idx_q[i*IW +: 3])*SAMPLE_WIDTH +: SAMPLE_WIDTH];
         if (pending_q[i] && (idx_q[i*IW+3 +: ADDR_WIDTH] == resp_addr)) match[i] = 1'b1;
      end
      if (!read_data_audio_axis_valid || (state_q == IDLE)) match = '0;
   end

   // Next-state logic and the read-address channel outputs.
   always_comb begin
      state_d              = state_q;
      v_d                  = v_q;
      cnt_d                = cnt_q;
      advance              = 1'b0;
      timeout_hit          = 1'b0;
      issue_set            = '0;
      read_addr_axis_valid = 1'b0;
      read_addr_axis_data  = '0;
      read_addr_axis_tlast = 1'b0;
      case (state_q)
         IDLE: begin
            if (sample_tick) begin
               state_d = ISSUE;
               v_d     = '0;
               cnt_d   = '0;
            end
         end
         ISSUE: begin
            if (act_q[v_q]) begin
               read_addr_axis_valid = 1'b1;
               read_addr_axis_data  = idx_q[int'(v_q)*IW+3 +: ADDR_WIDTH];
               read_addr_axis_tlast = !act_above;
               if (read_addr_axis_ready) begin
                  issue_set[v_q] = 1'b1;
                  advance        = 1'b1;
               end
            end else begin
               advance = 1'b1;
            end
            if (advance) begin
               if (v_q == VW'(VOICES - 1)) state_d = WAIT;
               else                        v_d     = v_q + 1'b1;
            end
         end
         WAIT: begin
            if (pending_q == '0) begin
               state_d = DONE;
            end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
               state_d     = DONE;
               timeout_hit = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM state, voice cursor and wait counter.
   always_ff @(posedge clk_dram_ctrl or negedge rst_dram_ctrl_n) begin
      if (!rst_dram_ctrl_n) begin
         state_q <= IDLE;
         v_q     <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         v_q     <= v_d;
         cnt_q   <= cnt_d;
      end
   end

   // Per-tick snapshot of the voice set plus pending/got bookkeeping and response capture.
   always_ff @(posedge clk_dram_ctrl or negedge rst_dram_ctrl_n) begin
      if (!rst_dram_ctrl_n) begin
         act_q     <= '0;
         idx_q     <= '0;
         pending_q <= '0;
         got_q     <= '0;
         for (int i = 0; i < VOICES; i++) shadow_q[i] <= '0;
      end else if (tick_accept) begin
         act_q     <= voice_active;
         idx_q     <= voice_sample_index;
         pending_q <= '0;
         got_q     <= '0;
      end else begin
         pending_q <= (pending_q & ~match) | issue_set;
         got_q     <= got_q | match;
         for (int i = 0; i < VOICES; i++) begin
            if (match[i]) shadow_q[i] <= resp_sample[i];
         end
      end
   end

   // Publish the sample set when the tick closes; timed-out voices keep their last value.
   always_ff @(posedge clk_dram_ctrl or negedge rst_dram_ctrl_n) begin
      if (!rst_dram_ctrl_n) begin
         voice_sample <= '0;
      end else if (state_q == DONE) begin
         for (int i = 0; i < VOICES; i++) begin
            if (!act_q[i])     voice_sample[i*SAMPLE_WIDTH +: SAMPLE_WIDTH] <= '0;
            else if (got_q[i]) voice_sample[i*SAMPLE_WIDTH +: SAMPLE_WIDTH] <= shadow_q[i];
         end
      end
   end

   // Single-cycle status pulses and the response-channel ready.
   always_ff @(posedge clk_dram_ctrl or negedge rst_dram_ctrl_n) begin
      if (!rst_dram_ctrl_n) begin
         read_data_audio_axis_ready <= 1'b0;
         samples_valid              <= 1'b0;
         fetch_timeout              <= 1'b0;
         tick_overrun               <= 1'b0;
         stale_drop                 <= 1'b0;
      end else begin
         read_data_audio_axis_ready <= 1'b1;
         samples_valid              <= (state_q == DONE);
         fetch_timeout              <= timeout_hit;
         tick_overrun               <= sample_tick && (state_q != IDLE);
         stale_drop                 <= read_data_audio_axis_valid &&
                                       ((state_q == IDLE) || (match == '0));
      end
   end

endmodule

// File: tb/tb_dram_audio_fetcher.sv
// Directed bench for dram_audio_fetcher: request ordering, sample capture,
// backpressure, timeout, overrun/stale pulses and mid-fetch reset.
module tb_dram_audio_fetcher;

   localparam int VOICES = 8;
   localparam int AW     = 24;
   localparam int SW     = 16;
   localparam int IW     = AW + 3;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic                  sample_tick;
   logic [VOICES-1:0]     voice_active;
   logic [VOICES*IW-1:0]  voice_sample_index;
   logic [AW-1:0]         ra_data;
   logic                  ra_valid;
   logic                  ra_ready;
   logic                  ra_tlast;
   logic [AW+127:0]       rd_data;
   logic                  rd_valid;
   logic                  rd_ready;
   logic [VOICES*SW-1:0]  voice_sample;
   logic                  samples_valid;
   logic                  fetch_timeout;
   logic                  tick_overrun;
   logic                  stale_drop;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [AW:0] exp_q[$];
   logic [AW:0] exp_e;
   int hs_seen = 0;
   int hs_exp  = 0;
   int sv_cnt  = 0;
   int to_cnt  = 0;
   int ov_cnt  = 0;
   int st_cnt  = 0;

   logic [VOICES*IW-1:0] idx;
   logic [127:0]         d;
   logic [127:0]         exp_vs;
   int                   n;
   int                   base;

   // Clock and DUT
   always #5 clk = ~clk;

   dram_audio_fetcher dut (
      .clk_dram_ctrl              (clk),
      .rst_dram_ctrl_n            (rst_n),
      .sample_tick                (sample_tick),
      .voice_active               (voice_active),
      .voice_sample_index         (voice_sample_index),
      .read_addr_axis_data        (ra_data),
      .read_addr_axis_valid       (ra_valid),
      .read_addr_axis_ready       (ra_ready),
      .read_addr_axis_tlast       (ra_tlast),
      .read_data_audio_axis_data  (rd_data),
      .read_data_audio_axis_valid (rd_valid),
      .read_data_audio_axis_ready (rd_ready),
      .voice_sample               (voice_sample),
      .samples_valid              (samples_valid),
      .fetch_timeout              (fetch_timeout),
      .tick_overrun               (tick_overrun),
      .stale_drop                 (stale_drop)
   );

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every address handshake is checked against the expected queue
   always @(negedge clk) begin
      if (ra_valid && ra_ready) begin
         hs_seen++;
         if (exp_q.size() > 0) begin
            exp_e = exp_q.pop_front();
            check("req_tlast_addr", {ra_tlast, ra_data}, exp_e);
         end
      end
      if (samples_valid) sv_cnt++;
      if (fetch_timeout) to_cnt++;
      if (tick_overrun)  ov_cnt++;
      if (stale_drop)    st_cnt++;
   end

   // Driver tasks
   task automatic step(input int cycles);
      repeat (cycles) @(posedge clk);
      #1;
   endtask

   task automatic expect_req(input logic [AW-1:0] word, input logic last);
      exp_q.push_back({last, word});
      hs_exp++;
   endtask

   task automatic send_tick(input logic [VOICES-1:0] act, input logic [VOICES*IW-1:0] ix);
      voice_active       = act;
      voice_sample_index = ix;
      sample_tick        = 1'b1;
      step(1);
      sample_tick        = 1'b0;
   endtask

   task automatic send_resp(input logic [AW-1:0] a, input logic [127:0] dat);
      rd_data  = {a, dat};
      rd_valid = 1'b1;
      step(1);
      rd_valid = 1'b0;
      rd_data  = '0;
   endtask

   task automatic wait_issued(input string tag, input int budget);
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < budget) begin
         step(1);
         k++;
      end
      check(tag, exp_q.size(), 0);
   endtask

   task automatic wait_sv(input string tag, input int target, input int budget);
      int k;
      k = 0;
      while (sv_cnt < target && k < budget) begin
         step(1);
         k++;
      end
      check(tag, sv_cnt, target);
   endtask

   function automatic logic [VOICES*IW-1:0] put_idx(input logic [VOICES*IW-1:0] b, input int v,
                                                    input logic [AW-1:0] word, input logic [2:0] lane);
      logic [VOICES*IW-1:0] r;
      r = b;
      r[v*IW +: IW] = {word, lane};
      return r;
   endfunction

   initial begin
      rst_n = 1'b0; sample_tick = 1'b0; voice_active = '0; voice_sample_index = '0;
      ra_ready = 1'b1; rd_data = '0; rd_valid = 1'b0;

      // Reset state
      step(3);
      check("rst_rd_ready_low", rd_ready, 0);
      check("rst_voice_sample", voice_sample, 0);
      rst_n = 1'b1;
      step(1);
      check("rd_ready_after_rst", rd_ready, 1);
      check("idle_valid", ra_valid, 0);
      check("idle_pulses", {samples_valid, fetch_timeout, tick_overrun, stale_drop}, 0);

      // Test 1: voice 0, word 2 lane 3
      idx = put_idx('0, 0, 24'h000002, 3'd3);
      check("t1_index_encoding", idx[26:0], 27'h13);
      expect_req(24'h000002, 1'b1);
      send_tick(8'h01, idx);
      wait_issued("t1_issued", 50);
      d = '0; d[63:48] = 16'hBEEF;
      send_resp(24'h000002, d);
      wait_sv("t1_samples_valid", 1, 50);
      exp_vs = '0; exp_vs[15:0] = 16'hBEEF;
      check("t1_voice_sample", voice_sample, exp_vs);
      step(5);
      check("t1_sv_once", sv_cnt, 1);
      check("t1_no_stale", st_cnt, 0);

      // Test 2: voices 1 and 5 share word 0x40 (lanes 0 and 7)
      idx = put_idx('0, 1, 24'h000040, 3'd0);
      idx = put_idx(idx, 5, 24'h000040, 3'd7);
      expect_req(24'h000040, 1'b0);
      expect_req(24'h000040, 1'b1);
      send_tick(8'h22, idx);
      wait_issued("t2_issued", 50);
      d = '0; d[15:0] = 16'h1111; d[127:112] = 16'h7777;
      send_resp(24'h000040, d);
      wait_sv("t2_samples_valid", 2, 50);
      exp_vs = '0; exp_vs[1*SW +: SW] = 16'h1111; exp_vs[5*SW +: SW] = 16'h7777;
      check("t2_voice_sample", voice_sample, exp_vs);
      check("t2_no_stale", st_cnt, 0);

      // Test 3: backpressure while voice 3 is presented
      ra_ready = 1'b0;
      idx = put_idx('0, 3, 24'h000123, 3'd1);
      idx = put_idx(idx, 6, 24'h000055, 3'd2);
      expect_req(24'h000123, 1'b0);
      expect_req(24'h000055, 1'b1);
      send_tick(8'h48, idx);
      step(3);
      for (int i = 0; i < 10; i++) begin
         check("t3_hold_valid", ra_valid, 1);
         check("t3_hold_data", ra_data, 24'h000123);
         check("t3_hold_tlast", ra_tlast, 0);
         step(1);
      end
      ra_ready = 1'b1;
      wait_issued("t3_issued", 50);
      d = '0; d[31:16] = 16'h3333;
      send_resp(24'h000123, d);
      d = '0; d[47:32] = 16'h6666;
      send_resp(24'h000055, d);
      wait_sv("t3_samples_valid", 3, 50);
      exp_vs = '0; exp_vs[3*SW +: SW] = 16'h3333; exp_vs[6*SW +: SW] = 16'h6666;
      check("t3_voice_sample", voice_sample, exp_vs);
      check("t3_handshake_count", hs_seen, hs_exp);

      // Test 4: voice 2 primed with 0x1234, then a fetch with no response
      idx = put_idx('0, 2, 24'h000077, 3'd4);
      expect_req(24'h000077, 1'b1);
      send_tick(8'h04, idx);
      wait_issued("t4_prime_issued", 50);
      d = '0; d[79:64] = 16'h1234;
      send_resp(24'h000077, d);
      wait_sv("t4_prime_sv", 4, 50);
      exp_vs = '0; exp_vs[2*SW +: SW] = 16'h1234;
      check("t4_prime_sample", voice_sample, exp_vs);
      expect_req(24'h000077, 1'b1);
      send_tick(8'h04, idx);
      n = 0;
      while (!fetch_timeout && n < 5000) begin
         step(1);
         n++;
      end
      // 8 ISSUE cycles + 4096 WAIT cycles before the DONE cycle
      check("t4_timeout_latency", n, 4104);
      check("t4_sv_not_yet", samples_valid, 0);
      step(1);
      check("t4_sv_after_done", samples_valid, 1);
      check("t4_timeout_single", fetch_timeout, 0);
      check("t4_sample_held", voice_sample, exp_vs);
      check("t4_timeout_count", to_cnt, 1);

      // Test 5: tick during WAIT is dropped; unsolicited response in IDLE is stale
      step(2);
      idx = put_idx('0, 0, 24'h000010, 3'd0);
      expect_req(24'h000010, 1'b1);
      send_tick(8'h01, idx);
      step(12);
      base = ov_cnt;
      send_tick(8'hFF, '0);
      step(2);
      check("t5_overrun_pulse", ov_cnt - base, 1);
      d = '0; d[15:0] = 16'h5555;
      send_resp(24'h000010, d);
      wait_sv("t5_samples_valid", 6, 50);
      exp_vs = '0; exp_vs[15:0] = 16'h5555;
      check("t5_voice_sample", voice_sample, exp_vs);
      check("t5_no_extra_req", hs_seen, hs_exp);
      step(2);
      base = st_cnt;
      send_resp(24'h000010, d);
      step(2);
      check("t5_stale_pulse", st_cnt - base, 1);
      check("t5_no_state_change", {ra_valid, 26'(sv_cnt)}, {1'b0, 26'd6});

      // Test 6: reset mid-WAIT, late response is stale, next tick is normal
      idx = put_idx('0, 4, 24'h000099, 3'd5);
      expect_req(24'h000099, 1'b1);
      send_tick(8'h10, idx);
      wait_issued("t6_issued", 50);
      step(10);
      rst_n = 1'b0;
      #1;
      check("t6_rst_voice_sample", voice_sample, 0);
      check("t6_rst_outputs", {ra_valid, rd_ready, samples_valid, fetch_timeout, tick_overrun, stale_drop}, 0);
      step(3);
      rst_n = 1'b1;
      step(2);
      base = st_cnt;
      d = '0; d[95:80] = 16'hABCD;
      send_resp(24'h000099, d);
      step(2);
      check("t6_late_stale", st_cnt - base, 1);
      expect_req(24'h000099, 1'b1);
      send_tick(8'h10, idx);
      wait_issued("t6_refetch_issued", 50);
      send_resp(24'h000099, d);
      wait_sv("t6_samples_valid", 7, 50);
      exp_vs = '0; exp_vs[4*SW +: SW] = 16'hABCD;
      check("t6_voice_sample", voice_sample, exp_vs);
      check("t6_handshake_count", hs_seen, hs_exp);
      check("t6_overrun_total", ov_cnt, 1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
